// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//
// Turns the two channels of a mechanical quadrature encoder into single-cycle
// step pulses plus a held direction level, for up/down counters.
//
// Processing chain per channel:
//   pin -> 2-flop synchroniser (s1, s2) -> debounce counter -> filtered bit f
// The pair {f_a, f_b} is followed as a Gray-code position. A signed phase
// accumulator collects quarter-steps. One step is emitted per full detent
// (four valid transitions in the same net direction).
//
// After reset the decoder sits in INIT until both synchronised channels have
// been quiet for DEBOUNCE_CYCLES cycles. It then adopts the resting position
// without producing a step or an error.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a channel must differ before f follows (1..255)
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//
// Ports:
//   Clock    in   rising-edge clock for all state
//   sResetn  in   asynchronous active-low reset, clears all state
//   enc_a    in   encoder channel A (asynchronous to Clock)
//   enc_b    in   encoder channel B (asynchronous to Clock)
//   step     out  one-cycle pulse per completed detent
//   updown   out  direction of the most recent step (1 = up), held
//   err      out  one-cycle pulse when both filtered channels change together
// -----------------------------------------------------------------------------
module quad_step_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic Clock,
    input  logic sResetn,
    input  logic enc_a,
    input  logic enc_b,
    output logic step,
    output logic updown,
    output logic err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e state_q, state_d;

    // Synchroniser flops.
    logic a_s1_q, a_s2_q;
    logic b_s1_q, b_s2_q;

    // Debounce state per channel.
    logic             f_a_q, f_a_d;
    logic             f_b_q, f_b_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

    // Snapshot of s2 used as the comparison reference while in INIT.
    logic snap_a_q, snap_a_d;
    logic snap_b_q, snap_b_d;

    // Filtered position seen on the previous cycle. A difference between it
    // and the current filtered position marks a transition to classify.
    logic [1:0] prev_q, prev_d;

    // Quarter-step accumulator. Only -3..+3 is ever stored, because reaching
    // +/-4 emits a step and clears it.
    logic signed [2:0] phase_q, phase_d;

    logic step_q, step_d;
    logic err_q, err_d;
    logic updown_q, updown_d;

    // Helper signals for the next-state logic.
    logic [1:0]        cur_pos;
    logic [1:0]        move;
    logic signed [3:0] ph_ext;
    logic signed [3:0] ph_next;
    logic              init_a_stable;
    logic              init_b_stable;

    // Map a Gray-coded AB pair to its index along the up sequence
    // 00 -> 01 -> 11 -> 10. The modulo-4 difference of two indices then
    // gives the move: 1 = up, 3 = down, 2 = both bits flipped (illegal).
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (ab)
            2'b00:   pos = 2'd0;
            2'b01:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    assign cur_pos = {f_a_q, f_b_q};
    assign move    = gray_pos(cur_pos) - gray_pos(prev_q);
    assign ph_ext  = {phase_q[2], phase_q};

    // In INIT, a channel counts as settled once s2 has matched its snapshot
    // for DEBOUNCE_CYCLES consecutive cycles. The counter saturates at
    // CNT_LAST, so a channel that settles early waits for the other one.
    assign init_a_stable = (a_s2_q == snap_a_q) && (cnt_a_q == CNT_LAST);
    assign init_b_stable = (b_s2_q == snap_b_q) && (cnt_b_q == CNT_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge sResetn) begin
        if (!sResetn) begin
            state_q  <= ST_INIT;
            a_s1_q   <= 1'b0;
            a_s2_q   <= 1'b0;
            b_s1_q   <= 1'b0;
            b_s2_q   <= 1'b0;
            f_a_q    <= 1'b0;
            f_b_q    <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            snap_a_q <= 1'b0;
            snap_b_q <= 1'b0;
            prev_q   <= 2'b00;
            phase_q  <= '0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            updown_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_s1_q   <= enc_a;
            a_s2_q   <= a_s1_q;
            b_s1_q   <= enc_b;
            b_s2_q   <= b_s1_q;
            f_a_q    <= f_a_d;
            f_b_q    <= f_b_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            snap_a_q <= snap_a_d;
            snap_b_q <= snap_b_d;
            prev_q   <= prev_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
            err_q    <= err_d;
            updown_q <= updown_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        f_a_d    = f_a_q;
        f_b_d    = f_b_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        snap_a_d = snap_a_q;
        snap_b_d = snap_b_q;
        prev_d   = prev_q;
        phase_d  = phase_q;
        updown_d = updown_q;
        step_d   = 1'b0;
        err_d    = 1'b0;
        ph_next  = ph_ext;

        case (state_q)
            ST_INIT: begin
                // Look for quiet inputs. Any change re-arms the snapshot.
                if (a_s2_q != snap_a_q) begin
                    snap_a_d = a_s2_q;
                    cnt_a_d  = '0;
                end else if (cnt_a_q != CNT_LAST) begin
                    cnt_a_d = cnt_a_q + CNT_ONE;
                end

                if (b_s2_q != snap_b_q) begin
                    snap_b_d = b_s2_q;
                    cnt_b_d  = '0;
                end else if (cnt_b_q != CNT_LAST) begin
                    cnt_b_d = cnt_b_q + CNT_ONE;
                end

                // Adopt the resting position silently. prev is loaded too,
                // so the first RUN cycle does not see a transition.
                if (init_a_stable && init_b_stable) begin
                    f_a_d   = a_s2_q;
                    f_b_d   = b_s2_q;
                    prev_d  = {a_s2_q, b_s2_q};
                    phase_d = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                prev_d = cur_pos;

                // Classify the filtered transition made on the previous edge.
                // This extra stage places step/err one edge after f moves.
                if (cur_pos != prev_q) begin
                    case (move)
                        2'd1:    ph_next = ph_ext + 4'sd1;
                        2'd3:    ph_next = ph_ext - 4'sd1;
                        default: ph_next = ph_ext;
                    endcase

                    if (move == 2'd2) begin
                        // The new position is kept. Any partial detent is lost.
                        err_d   = 1'b1;
                        phase_d = '0;
                    end else if (ph_next == 4'sd4) begin
                        step_d   = 1'b1;
                        updown_d = 1'b1;
                        phase_d  = '0;
                    end else if (ph_next == -4'sd4) begin
                        step_d   = 1'b1;
                        updown_d = 1'b0;
                        phase_d  = '0;
                    end else begin
                        phase_d = ph_next[2:0];
                    end
                end

                // Debounce: f follows s2 only after DEBOUNCE_CYCLES consecutive
                // cycles of disagreement. A shorter glitch clears the count.
                if (a_s2_q == f_a_q) begin
                    cnt_a_d = '0;
                end else if (cnt_a_q == CNT_LAST) begin
                    f_a_d   = a_s2_q;
                    cnt_a_d = '0;
                end else begin
                    cnt_a_d = cnt_a_q + CNT_ONE;
                end

                if (b_s2_q == f_b_q) begin
                    cnt_b_d = '0;
                end else if (cnt_b_q == CNT_LAST) begin
                    f_b_d   = b_s2_q;
                    cnt_b_d = '0;
                end else begin
                    cnt_b_d = cnt_b_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign step   = step_q;
    assign err    = err_q;
    assign updown = updown_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
module tb_quad_step_decoder;

    localparam int D = 4;

    logic Clock   = 1'b0;
    logic sResetn = 1'b0;
    logic enc_a   = 1'b0;
    logic enc_b   = 1'b0;
    logic step;
    logic updown;
    logic err;

    quad_step_decoder #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(8)
    ) dut (
        .Clock(Clock),
        .sResetn(sResetn),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .step(step),
        .updown(updown),
        .err(err)
    );

    always #5 Clock = ~Clock;

    int n_vec    = 0;
    int n_bad    = 0;
    int step_cnt = 0;
    int err_cnt  = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the pins through two sample delays, then filters each channel by
    // run length. The position is an index 0..3 along the up sequence. Phase
    // is a plain integer. Outputs appear one edge after the filtered move.
    logic [1:0] m_s1, m_s2, m_f, m_prevf, m_last;
    int         m_run[2];
    int         m_stab[2];
    bit         m_running;
    int         m_phase;
    logic       m_step, m_err, m_up;

    function automatic int gpos(input logic [1:0] g);
        if (g == 2'b00) return 0;
        if (g == 2'b01) return 1;
        if (g == 2'b11) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_f = 2'b00; m_prevf = 2'b00; m_last = 2'b00;
        m_run[0] = 0; m_run[1] = 0; m_stab[0] = 0; m_stab[1] = 0;
        m_running = 1'b0; m_phase = 0;
        m_step = 1'b0; m_err = 1'b0; m_up = 1'b1;
    endtask

    task automatic model_edge(input logic a, input logic b);
        logic [1:0] os1, os2, of, op;
        int mv;
        os1 = m_s1; os2 = m_s2; of = m_f; op = m_prevf;
        m_step = 1'b0;
        m_err  = 1'b0;
        if (m_running) begin
            if (of != op) begin
                mv = (gpos(of) - gpos(op) + 4) % 4;
                if (mv == 2) begin
                    m_err = 1'b1;
                    m_phase = 0;
                end else begin
                    m_phase += (mv == 1) ? 1 : -1;
                    if (m_phase == 4 || m_phase == -4) begin
                        m_step  = 1'b1;
                        m_up    = (m_phase == 4);
                        m_phase = 0;
                    end
                end
            end
            m_prevf = of;
            for (int ch = 0; ch < 2; ch++) begin
                if (os2[ch] != of[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D) begin
                        m_f[ch]   = os2[ch];
                        m_run[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (os2[ch] == m_last[ch]) m_stab[ch]++;
                else m_stab[ch] = 0;
            end
            m_last = os2;
            if (m_stab[0] >= D && m_stab[1] >= D) begin
                m_f = os2; m_prevf = os2; m_phase = 0;
                m_run[0] = 0; m_run[1] = 0;
                m_running = 1'b1;
            end
        end
        m_s2 = os1;
        m_s1 = {a, b};
    endtask

    always @(posedge Clock) begin
        if (!sResetn) model_reset();
        else model_edge(enc_a, enc_b);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clock) begin
        if (cmp_en) begin
            check("step", int'(step), int'(m_step));
            check("err", int'(err), int'(m_err));
            check("updown", int'(updown), int'(m_up));
            check("step_err_exclusive", int'(step & err), 0);
            if (step) step_cnt++;
            if (err) err_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic set_ab(input logic a, input logic b, input int hold);
        enc_a = a;
        enc_b = b;
        tick(hold);
    endtask

    task automatic do_reset(input logic a, input logic b);
        sResetn = 1'b0;
        model_reset();
        enc_a = a;
        enc_b = b;
        tick(2);
        sResetn = 1'b1;
        tick(20);
    endtask

    // Apply a new AB value and count edges from the capturing edge to step.
    task automatic drive_and_time(input logic a, input logic b, output int lat);
        enc_a = a;
        enc_b = b;
        lat = -1;
        for (int i = 0; i <= 20; i++) begin
            @(posedge Clock);
            #1;
            if (step) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pulse_a(input int len, output int hi);
        hi = 0;
        enc_a = 1'b1;
        for (int i = 0; i < len; i++) begin
            tick(1);
            if (dut.f_a_q) hi++;
        end
        enc_a = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (dut.f_a_q) hi++;
        end
    endtask

    int s0, e0, lat, hi;

    initial begin
        model_reset();
        cmp_en = 1'b1;

        // Resting at 11 through reset: silent adoption.
        do_reset(1'b1, 1'b1);
        tick(30);
        check("init_f", int'({dut.f_a_q, dut.f_b_q}), 3);
        check("init_phase", int'(dut.phase_q), 0);
        check("init_updown", int'(updown), 1);
        check("init_steps", step_cnt, 0);
        check("init_errs", err_cnt, 0);
        check("model_init_f", int'(m_f), 3);

        // One up detent from 00.
        do_reset(1'b0, 1'b0);
        s0 = step_cnt;
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b1, 1'b0, 10);
        drive_and_time(1'b0, 1'b0, lat);
        check("up_latency", lat, 6);
        tick(10);
        check("up_steps", step_cnt - s0, 1);
        check("up_dir", int'(updown), 1);

        // One down detent.
        s0 = step_cnt;
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b0, 1'b1, 10);
        drive_and_time(1'b0, 1'b0, lat);
        check("down_latency", lat, 6);
        tick(10);
        check("down_steps", step_cnt - s0, 1);
        check("down_dir", int'(updown), 0);

        // +3, -2, then +3: net +4 gives exactly one step at the very end.
        s0 = step_cnt;
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b1, 1'b0, 10);
        check("mixed_nostep", step_cnt - s0, 0);
        check("mixed_phase", int'(dut.phase_q), 3);
        check("model_mixed_phase", m_phase, 3);
        set_ab(1'b0, 1'b0, 10);
        check("mixed_steps", step_cnt - s0, 1);
        check("mixed_dir", int'(updown), 1);

        // Glitches on channel A.
        s0 = step_cnt;
        e0 = err_cnt;
        pulse_a(3, hi);
        check("glitch3_fa_high", hi, 0);
        pulse_a(4, hi);
        check("glitch4_fa_high", hi, 4);
        check("glitch_steps", step_cnt - s0, 0);
        check("glitch_errs", err_cnt - e0, 0);
        check("glitch_phase", int'(dut.phase_q), 0);

        // Illegal 00 -> 11, then a valid up detent from 11.
        s0 = step_cnt;
        e0 = err_cnt;
        set_ab(1'b1, 1'b1, 15);
        check("illegal_errs", err_cnt - e0, 1);
        check("illegal_steps", step_cnt - s0, 0);
        check("illegal_phase", int'(dut.phase_q), 0);
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b0, 1'b0, 10);
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b1, 1'b1, 10);
        check("after_illegal_steps", step_cnt - s0, 1);
        check("after_illegal_dir", int'(updown), 1);

        // Down detent (updown=0), then +3, then reset mid-detent.
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b0, 1'b0, 10);
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b1, 1'b1, 10);
        check("pre_rst_dir", int'(updown), 0);
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b0, 1'b0, 10);
        set_ab(1'b0, 1'b1, 10);
        check("pre_rst_phase", int'(dut.phase_q), 3);
        sResetn = 1'b0;
        model_reset();
        #1;
        check("rst_step", int'(step), 0);
        check("rst_err", int'(err), 0);
        check("rst_updown", int'(updown), 1);
        check("rst_phase", int'(dut.phase_q), 0);
        tick(1);
        sResetn = 1'b1;
        tick(20);
        s0 = step_cnt;
        set_ab(1'b1, 1'b1, 12);
        check("post_rst_steps", step_cnt - s0, 0);
        check("post_rst_phase", int'(dut.phase_q), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
